// File: rtl/match_len_checker_pkg.sv
// Shared widths and types for the match length checker.
//   ADDR_WIDTH      byte address width of window/input positions
//   MATCH_PU_WIDTH  bytes compared per request
//   LEN_WIDTH       width of a length value (0..MATCH_PU_WIDTH plus clamp headroom)
//   meta_t          per-request data travelling alongside the window read
package match_len_checker_pkg;
  localparam int ADDR_WIDTH          = 16;
  localparam int MATCH_PU_WIDTH      = 8;
  localparam int MATCH_PU_WIDTH_LOG2 = 3;
  localparam int LEN_WIDTH           = MATCH_PU_WIDTH_LOG2 + 1;
  localparam int DATA_WIDTH          = MATCH_PU_WIDTH * 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] cur_data;
    logic [LEN_WIDTH-1:0]  max_len;
    logic                  addr_bad;
  } meta_t;
endpackage

// File: rtl/match_len_checker_lead_eq_count.sv
// Leading-ones counter: returns the index of the first 0 in eq_i (LSB first),
// or W when every bit is set.
//   eq_i   per-byte equality vector, bit 0 = first byte
//   cnt_o  leading match count 0..W
module match_len_checker_lead_eq_count #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic [W-1:0]  eq_i,
  output logic [CW-1:0] cnt_o
);
  // Scan from the top so the lowest zero wins.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (!eq_i[i]) cnt_o = CW'(i);
    end
  end
endmodule

// File: rtl/match_len_checker.sv
// Match length checker: issues one window read per candidate request, compares
// the returned word against the lookahead bytes and reports the leading match
// length in request order. One request per cycle; stalls only on res_ready.
//   clk, rst_n            clock, synchronous active-low reset
//   req_*                 candidate request (valid/ready handshake)
//   win_read_*            window buffer read port (READ_LAT = NBPIPE+1)
//   res_*                 result (valid/ready handshake), len/hit/tag
module match_len_checker
  import match_len_checker_pkg::*;
#(
  parameter int NBPIPE    = 3,
  parameter int TAG_WIDTH = 8,
  parameter int MIN_MATCH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_cand_addr,
  input  logic [ADDR_WIDTH-1:0] req_cur_addr,
  input  logic [DATA_WIDTH-1:0] req_cur_data,
  input  logic [LEN_WIDTH-1:0]  req_max_len,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  win_read_enable,
  output logic [ADDR_WIDTH-1:0] win_read_address,
  input  logic                  win_read_unsafe,
  input  logic [DATA_WIDTH-1:0] win_read_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [LEN_WIDTH-1:0]  res_len,
  output logic                  res_hit,
  output logic [TAG_WIDTH-1:0]  res_tag
);
  localparam int READ_LAT = NBPIPE + 1;
  localparam logic [LEN_WIDTH-1:0] PU_LEN  = LEN_WIDTH'(MATCH_PU_WIDTH);
  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_MATCH);

  logic                  adv;
  logic [READ_LAT-1:0]   vld_pipe_q;
  meta_t                 meta_q     [READ_LAT];
  logic [TAG_WIDTH-1:0]  tag_pipe_q [READ_LAT];
  meta_t                 meta_d;
  logic [MATCH_PU_WIDTH-1:0] eq;
  logic [LEN_WIDTH-1:0]  raw, lim, len_d;
  logic                  hit_d;
  logic                  res_valid_q, res_hit_q;
  logic [LEN_WIDTH-1:0]  res_len_q;
  logic [TAG_WIDTH-1:0]  res_tag_q;

  // Whole pipeline (window + meta + output) moves in lockstep on adv.
  assign adv              = ~res_valid_q | res_ready;
  assign req_ready        = adv;
  assign win_read_enable  = adv & rst_n;
  assign win_read_address = req_cand_addr;

  always_comb begin
    meta_d          = '0;
    meta_d.cur_data = req_cur_data;
    meta_d.max_len  = req_max_len;
    meta_d.addr_bad = (req_cand_addr >= req_cur_addr);
  end

  // Last meta stage lines up with the window data.
  for (genvar i = 0; i < MATCH_PU_WIDTH; i++) begin : g_eq
    assign eq[i] = (win_read_data[8*i +: 8] == meta_q[READ_LAT-1].cur_data[8*i +: 8]);
  end

  match_len_checker_lead_eq_count #(.W(MATCH_PU_WIDTH), .CW(LEN_WIDTH)) u_lec (
    .eq_i  (eq),
    .cnt_o (raw)
  );

  always_comb begin
    lim   = (meta_q[READ_LAT-1].max_len > PU_LEN) ? PU_LEN : meta_q[READ_LAT-1].max_len;
    len_d = (raw < lim) ? raw : lim;
    if (win_read_unsafe | meta_q[READ_LAT-1].addr_bad) len_d = '0;
    hit_d = (len_d >= MIN_LEN);
  end

  // Payload stages need no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      meta_q[0]     <= meta_d;
      tag_pipe_q[0] <= req_tag;
      for (int s = 1; s < READ_LAT; s++) begin
        meta_q[s]     <= meta_q[s-1];
        tag_pipe_q[s] <= tag_pipe_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      res_valid_q <= 1'b0;
      res_len_q   <= '0;
      res_hit_q   <= 1'b0;
      res_tag_q   <= '0;
    end else if (adv) begin
      vld_pipe_q  <= {vld_pipe_q[READ_LAT-2:0], req_valid};
      res_valid_q <= vld_pipe_q[READ_LAT-1];
      res_len_q   <= len_d;
      res_hit_q   <= hit_d;
      res_tag_q   <= tag_pipe_q[READ_LAT-1];
    end
  end

  assign res_valid = res_valid_q;
  assign res_len   = res_len_q;
  assign res_hit   = res_hit_q;
  assign res_tag   = res_tag_q;
endmodule

// File: tb/tb_match_len_checker.sv
module tb_match_len_checker;
  import match_len_checker_pkg::*;
  localparam int NBPIPE   = 3;
  localparam int READ_LAT = NBPIPE + 1;

  logic                  clk = 0;
  logic                  rst_n = 0;
  logic                  req_valid = 0, req_ready;
  logic [ADDR_WIDTH-1:0] req_cand_addr = 0, req_cur_addr = 0;
  logic [DATA_WIDTH-1:0] req_cur_data = 0;
  logic [LEN_WIDTH-1:0]  req_max_len = 0;
  logic [7:0]            req_tag = 0;
  logic                  win_read_enable;
  logic [ADDR_WIDTH-1:0] win_read_address;
  logic                  win_read_unsafe;
  logic [DATA_WIDTH-1:0] win_read_data;
  logic                  res_valid, res_ready = 0, res_hit;
  logic [LEN_WIDTH-1:0]  res_len;
  logic [7:0]            res_tag;

  always #5 clk = ~clk;

  match_len_checker #(.NBPIPE(NBPIPE), .TAG_WIDTH(8), .MIN_MATCH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cand_addr(req_cand_addr), .req_cur_addr(req_cur_addr),
    .req_cur_data(req_cur_data), .req_max_len(req_max_len), .req_tag(req_tag),
    .win_read_enable(win_read_enable), .win_read_address(win_read_address),
    .win_read_unsafe(win_read_unsafe), .win_read_data(win_read_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_len(res_len), .res_hit(res_hit), .res_tag(res_tag)
  );

  // Window buffer: 256-word memory, READ_LAT-deep read pipe advanced on enable.
  logic [63:0] mem  [256];
  logic        umem [256];
  logic [63:0] wd_pipe [READ_LAT];
  logic        wu_pipe [READ_LAT];
  initial for (int i = 0; i < READ_LAT; i++) begin wd_pipe[i] = 0; wu_pipe[i] = 0; end
  always @(posedge clk) begin
    if (win_read_enable) begin
      wd_pipe[0] <= mem[win_read_address[7:0]];
      wu_pipe[0] <= umem[win_read_address[7:0]];
      for (int i = 1; i < READ_LAT; i++) begin
        wd_pipe[i] <= wd_pipe[i-1];
        wu_pipe[i] <= wu_pipe[i-1];
      end
    end
  end
  assign win_read_data   = wd_pipe[READ_LAT-1];
  assign win_read_unsafe = wu_pipe[READ_LAT-1];

  int total = 0, bad = 0;
  int npush = 0, npop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: count equal leading bytes, clamp, zero out unsafe/bad-address.
  function automatic int model_len(logic [15:0] cand, logic [15:0] cur,
                                   logic [63:0] cd, int ml);
    logic [63:0] w;
    int n;
    w = mem[cand[7:0]];
    n = 0;
    while (n < 8 && w[8*n +: 8] == cd[8*n +: 8]) n++;
    if (ml > 8) ml = 8;
    if (n > ml) n = ml;
    if (umem[cand[7:0]] || cand >= cur) n = 0;
    return n;
  endfunction

  typedef struct { int len; logic hit; logic [7:0] tag; } exp_t;
  exp_t q[$];
  logic hold = 0;
  logic [3:0] h_len; logic h_hit; logic [7:0] h_tag;

  // Compare process: handshakes, stability under stall, enable vs stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold = 0;
      chk("wre_in_reset", win_read_enable, 0);
    end else begin
      chk("wre_vs_stall", win_read_enable, (!res_valid || res_ready));
      chk("req_ready", req_ready, (!res_valid || res_ready));
      if (hold) chk("stable_while_stalled", {res_valid, res_len, res_hit, res_tag},
                    {1'b1, h_len, h_hit, h_tag});
      if (res_valid && res_ready) begin
        if (q.size() == 0) chk("spurious_result", res_valid, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          npop++;
          chk("res_len_hit_tag", {res_len, res_hit, res_tag},
              {4'(e.len), e.hit, e.tag});
        end
      end
      hold  = res_valid && !res_ready;
      h_len = res_len; h_hit = res_hit; h_tag = res_tag;
      if (req_valid && req_ready) begin
        exp_t e;
        e.len = model_len(req_cand_addr, req_cur_addr, req_cur_data, int'(req_max_len));
        e.hit = (e.len >= 4);
        e.tag = req_tag;
        q.push_back(e);
        npush++;
      end
    end
  end

  task automatic set_req(input logic [15:0] cand, input logic [15:0] cur,
                         input logic [63:0] cd, input logic [3:0] ml, input logic [7:0] tg);
    req_valid = 1; req_cand_addr = cand; req_cur_addr = cur;
    req_cur_data = cd; req_max_len = ml; req_tag = tg;
  endtask

  // One request with res_ready held high; literal expectation and latency.
  task automatic directed(input string nm, input logic [15:0] cand, input logic [15:0] cur,
                          input logic [63:0] cd, input logic [3:0] ml, input logic [7:0] tg,
                          input int exp_len, input logic exp_hit);
    int cnt;
    res_ready = 1;
    set_req(cand, cur, cd, ml, tg);
    @(posedge clk); #1;
    req_valid = 0;
    for (cnt = 1; cnt <= 20; cnt++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    chk({nm, "_latency"}, cnt, READ_LAT + 1);
    chk({nm, "_len"}, res_len, exp_len);
    chk({nm, "_hit"}, res_hit, exp_hit);
    chk({nm, "_tag"}, res_tag, tg);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_req_data(input logic [15:0] cand);
    logic [63:0] d;
    int k;
    d = mem[cand[7:0]];
    k = $urandom_range(0, 9);
    if (k < 8) d[8*k +: 8] = d[8*k +: 8] ^ 8'($urandom_range(1, 255));
    return d;
  endfunction

  task automatic rand_fields();
    logic [15:0] cand;
    cand = 16'($urandom);
    set_req(cand, ($urandom_range(0, 7) == 0) ? cand - 16'($urandom_range(0, 3))
                                              : cand + 16'($urandom_range(1, 4000)),
            rand_req_data(cand),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd8,
            8'($urandom));
  endtask

  logic [63:0] w;
  int nv;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = {$urandom, $urandom};
      umem[i] = ($urandom_range(0, 7) == 0);
    end
    umem[100] = 0; umem[101] = 0; umem[102] = 1; umem[103] = 0; umem[44] = 0;

    // Reset state
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_len", res_len, 0);
    chk("rst_res_hit", res_hit, 0);
    chk("rst_res_tag", res_tag, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1);
    @(posedge clk); #1;

    // Directed cases with hand-computed results
    directed("all_equal", 100, 200, mem[100], 4'd8, 8'h5A, 8, 1);
    w = mem[101]; w[47:40] = w[47:40] ^ 8'h01;
    directed("byte5_diff", 101, 200, w, 4'd8, 8'h11, 5, 1);
    w = mem[101]; w[7:0] = w[7:0] ^ 8'h80;
    directed("byte0_diff", 101, 200, w, 4'd8, 8'h12, 0, 0);
    directed("unsafe", 102, 200, mem[102], 4'd8, 8'h13, 0, 0);
    directed("cand_eq_cur", 300, 300, mem[44], 4'd8, 8'h14, 0, 0);
    directed("maxlen3", 103, 200, mem[103], 4'd3, 8'h15, 3, 0);
    directed("maxlen15_clamp", 103, 200, mem[103], 4'd15, 8'h16, 8, 1);
    directed("maxlen4_hit", 103, 200, mem[103], 4'd4, 8'h17, 4, 1);
    directed("wrap_cand_gt_cur", 16'hFF64, 16'h0010, mem[8'h64], 4'd8, 8'h18, 0, 0);

    // 20 back-to-back requests under random backpressure; each held until taken
    for (int n = 0; n < 20; n++) begin
      logic acc;
      rand_fields();
      do begin
        res_ready = $urandom_range(0, 1);
        @(negedge clk);
        acc = req_ready;
        @(posedge clk); #1;
      end while (!acc);
    end
    req_valid = 0;

    // Free-running random traffic
    repeat (400) begin
      if ($urandom_range(0, 3) != 0) rand_fields(); else req_valid = 0;
      res_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    req_valid = 0; res_ready = 1;
    repeat (READ_LAT + 6) @(posedge clk);
    #1;
    chk("drain_queue_empty", q.size(), 0);
    chk("push_pop_count", npop, npush);

    // Reset with three requests in flight
    res_ready = 1;
    for (int n = 0; n < 3; n++) begin
      set_req(100, 200, mem[100], 4'd8, 8'hA0 + 8'(n));
      @(posedge clk); #1;
    end
    req_valid = 0;
    rst_n = 0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_res_valid", res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) nv++;
    end
    chk("no_stale_after_reset", nv, 0);

    // Traffic resumes normally after the mid-flight reset
    @(posedge clk); #1;
    directed("post_reset", 100, 200, mem[100], 4'd8, 8'h77, 8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
